// File: rtl/audio_capture_if.sv
// audio_capture_if
//
// Groups the capture control, ADC sample stream, read port and status signals
// of audio_capture into one bundle.
//
// Signals:
//   start         master->slave  one-cycle pulse that arms capture
//   sample_in     master->slave  ADC sample, unsigned offset binary
//   sample_valid  master->slave  sample_in is valid this cycle
//   rd_addr       master->slave  buffer read address
//   rd_data       slave->master  registered buffer word at rd_addr
//   sample_count  slave->master  samples stored in the current capture
//   busy          slave->master  high while armed or capturing
//   capture_done  slave->master  high once a full clip is stored
//   state         slave->master  3-bit phase code
//
// Modports: master = sample source / correlator side, slave = audio_capture.

interface audio_capture_if #(
    parameter int WIDTH = 10,
    parameter int AW    = 11
);
    logic             start;
    logic [WIDTH-1:0] sample_in;
    logic             sample_valid;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic [AW-1:0]    sample_count;
    logic             busy;
    logic             capture_done;
    logic [2:0]       state;

    modport master (
        output start, sample_in, sample_valid, rd_addr,
        input  rd_data, sample_count, busy, capture_done, state
    );

    modport slave (
        input  start, sample_in, sample_valid, rd_addr,
        output rd_data, sample_count, busy, capture_done, state
    );
endinterface

// File: rtl/audio_capture.sv
// audio_capture
//
// Front end of the keyword matcher. Waits armed for a sound onset, where the
// sample's distance from midscale reaches THRESH, then stores exactly DEPTH
// consecutive valid samples (the triggering one is word 0) into an on-chip
// buffer. The buffer is read back through a registered read port.
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset
//   bus    audio_capture_if.slave (start, sample stream, read port, status)
//
// Build option:
//   AUDIO_CAPTURE_DC_REMOVE_EN  when defined, each word is stored as
//   sample_in - midscale in two's complement instead of the raw sample.
//   Onset detection does not depend on it.

module audio_capture #(
    parameter int DEPTH  = 2000,
    parameter int WIDTH  = 10,
    parameter int THRESH = 64
) (
    input  logic             clk,
    input  logic             reset,
    audio_capture_if.slave   bus
);
    localparam int AW  = 11;
    localparam int MID = 1 << (WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        CAPTURE = 3'd2,
        DONE    = 3'd3
    } state_t;

    state_t           state_q;
    logic [AW-1:0]    count_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] rd_q;

    logic signed [WIDTH:0] centred;
    logic [WIDTH:0]        magnitude;
    logic                  onset;
    logic                  we;
    logic [AW-1:0]         wr_addr;
    logic [WIDTH-1:0]      wr_word;

    // Block RAM array; deliberately not reset so it maps onto a RAM macro.
    logic [WIDTH-1:0] mem [0:DEPTH-1];

    // Onset detection: |sample - midscale| on one extra bit of signed range.
    always_comb begin
        centred   = $signed({1'b0, bus.sample_in}) - $signed((WIDTH+1)'(MID));
        magnitude = centred[WIDTH] ? $unsigned(-centred) : $unsigned(centred);
        onset     = (magnitude >= (WIDTH+1)'(THRESH));
    end

    // Write side: the trigger sample lands at word 0, later ones at the
    // running count.
    always_comb begin
        we      = bus.sample_valid &&
                  (((state_q == ARMED) && onset) || (state_q == CAPTURE));
        wr_addr = (state_q == CAPTURE) ? count_q : '0;
`ifdef AUDIO_CAPTURE_DC_REMOVE_EN
        wr_word = bus.sample_in - WIDTH'(MID);
`else
        wr_word = bus.sample_in;
`endif
    end

    // Capture sequencer with registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q <= ARMED;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ARMED: begin
                    if (bus.sample_valid && onset) begin
                        count_q <= AW'(1);
                        if (DEPTH == 1) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    if (bus.sample_valid) begin
                        count_q <= count_q + AW'(1);
                        if (count_q == AW'(DEPTH - 1)) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // A sample arriving with start is not onset-tested; testing
                    // begins once ARMED is actually entered.
                    if (bus.start) begin
                        state_q <= ARMED;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    count_q <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_word;
        end
    end

    // Registered read; a same-cycle write to the same word returns old data.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q <= '0;
        end else if (bus.rd_addr < AW'(DEPTH)) begin
            rd_q <= mem[bus.rd_addr];
        end else begin
            rd_q <= '0;
        end
    end

    assign bus.rd_data      = rd_q;
    assign bus.sample_count = count_q;
    assign bus.busy         = busy_q;
    assign bus.capture_done = done_q;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_audio_capture.sv
// tb_audio_capture
//
// Directed bench for audio_capture. Inputs change on the falling edge and
// outputs are inspected on the following falling edge, half a cycle after
// the rising edge that updates them. exp_mem mirrors what the buffer should
// hold, built from the samples the bench itself feeds in.

module tb_audio_capture;
    localparam int DEPTH = 2000;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    logic [9:0] exp_mem [0:DEPTH-1];

    audio_capture_if #(.WIDTH(10), .AW(11)) bus ();

    audio_capture #(.DEPTH(DEPTH), .WIDTH(10), .THRESH(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Value the buffer should hold for a given input sample.
    function automatic logic [9:0] stored(input logic [9:0] s);
`ifdef AUDIO_CAPTURE_DC_REMOVE_EN
        return s - 10'd512;
`else
        return s;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic feed(input logic [9:0] s);
        bus.sample_in    = s;
        bus.sample_valid = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.sample_in = 10'd800;
        bus.rd_addr   = 11'd2000;
        bus.sample_valid = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
        bus.start = 1'b1;
        tick();
        total++; if (bus.state !== 3'd0) begin bad++; $display("[TB] FAIL reset_state got=%0d want=0", bus.state); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.capture_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b want=0", bus.capture_done); end
        total++; if (bus.sample_count !== 11'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d want=0", bus.sample_count); end
        total++; if (bus.rd_data !== 10'd0) begin bad++; $display("[TB] FAIL reset_rd_data got=%0d want=0", bus.rd_data); end
        reset = 1'b0;
        bus.start = 1'b0;
        feed(10'd800);
        feed(10'd100);
        total++; if (bus.state !== 3'd0) begin bad++; $display("[TB] FAIL idle_no_start got=%0d want=0", bus.state); end
        total++; if (bus.sample_count !== 11'd0) begin bad++; $display("[TB] FAIL idle_count got=%0d want=0", bus.sample_count); end
    endtask

    task automatic test_onset();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        total++; if (bus.state !== 3'd1) begin bad++; $display("[TB] FAIL arm_state got=%0d want=1", bus.state); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL arm_busy got=%b want=1", bus.busy); end
        feed(10'd512);
        total++; if (bus.state !== 3'd1) begin bad++; $display("[TB] FAIL onset_512 got=%0d want=1", bus.state); end
        feed(10'd575);
        total++; if (bus.state !== 3'd1) begin bad++; $display("[TB] FAIL onset_575 got=%0d want=1", bus.state); end
        feed(10'd450);
        total++; if (bus.state !== 3'd1) begin bad++; $display("[TB] FAIL onset_450 got=%0d want=1", bus.state); end
        total++; if (bus.sample_count !== 11'd0) begin bad++; $display("[TB] FAIL armed_count got=%0d want=0", bus.sample_count); end
        bus.rd_addr = 11'd0;
        feed(10'd576);
        exp_mem[0] = stored(10'd576);
        total++; if (bus.state !== 3'd2) begin bad++; $display("[TB] FAIL onset_576 got=%0d want=2", bus.state); end
        total++; if (bus.sample_count !== 11'd1) begin bad++; $display("[TB] FAIL trigger_count got=%0d want=1", bus.sample_count); end
        tick();
        total++; if (bus.rd_data !== exp_mem[0]) begin bad++; $display("[TB] FAIL trigger_word got=%h want=%h", bus.rd_data, exp_mem[0]); end
    endtask

    task automatic test_full_capture();
        logic [9:0] s;
        for (int k = 1; k < DEPTH; k++) begin
            s = 10'((k * 3 + 5) % 1024);
            exp_mem[k] = stored(s);
            feed(s);
            if (k == 500) begin
                total++; if (bus.sample_count !== 11'd501) begin bad++; $display("[TB] FAIL count_500 got=%0d want=501", bus.sample_count); end
            end
            if (k == DEPTH - 2) begin
                total++; if (bus.capture_done !== 1'b0) begin bad++; $display("[TB] FAIL done_early got=%b want=0", bus.capture_done); end
                total++; if (bus.sample_count !== 11'd1999) begin bad++; $display("[TB] FAIL count_1999 got=%0d want=1999", bus.sample_count); end
            end
            if (k == 1000) begin
                bus.start = 1'b1;
                tick();
                bus.start = 1'b0;
                total++; if (bus.state !== 3'd2 || bus.sample_count !== 11'd1001) begin
                    bad++; $display("[TB] FAIL start_in_capture state=%0d count=%0d want 2/1001", bus.state, bus.sample_count);
                end
                tick();
            end else if (k < DEPTH - 1) begin
                tick();
                tick();
            end
        end
        total++; if (bus.capture_done !== 1'b1) begin bad++; $display("[TB] FAIL done_rise got=%b want=1", bus.capture_done); end
        total++; if (bus.state !== 3'd3) begin bad++; $display("[TB] FAIL done_state got=%0d want=3", bus.state); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL done_busy got=%b want=0", bus.busy); end
        total++; if (bus.sample_count !== 11'd2000) begin bad++; $display("[TB] FAIL done_count got=%0d want=2000", bus.sample_count); end
        feed(10'h2AA);
        feed(10'h155);
        feed(10'h3FF);
        total++; if (bus.sample_count !== 11'd2000 || bus.state !== 3'd3) begin
            bad++; $display("[TB] FAIL done_frozen count=%0d state=%0d want 2000/3", bus.sample_count, bus.state);
        end
    endtask

    task automatic test_read_port();
        logic [10:0] addrs [6];
        logic [9:0]  want;
        addrs = '{11'd0, 11'd1, 11'd1000, 11'd1999, 11'd2000, 11'd2047};
        for (int i = 0; i < 6; i++) begin
            bus.rd_addr = addrs[i];
            tick();
            want = (addrs[i] < 11'd2000) ? exp_mem[addrs[i]] : 10'd0;
            total++; if (bus.rd_data !== want) begin bad++; $display("[TB] FAIL read_%0d got=%h want=%h", addrs[i], bus.rd_data, want); end
        end
    endtask

    task automatic test_done_restart();
        bus.start = 1'b1;
        bus.sample_in = 10'd900;
        bus.sample_valid = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.sample_valid = 1'b0;
        total++; if (bus.state !== 3'd1 || bus.sample_count !== 11'd0) begin
            bad++; $display("[TB] FAIL rearm state=%0d count=%0d want 1/0", bus.state, bus.sample_count);
        end
        total++; if (bus.capture_done !== 1'b0 || bus.busy !== 1'b1) begin
            bad++; $display("[TB] FAIL rearm_flags done=%b busy=%b want 0/1", bus.capture_done, bus.busy);
        end
        feed(10'd512);
        total++; if (bus.state !== 3'd1) begin bad++; $display("[TB] FAIL rearm_quiet got=%0d want=1", bus.state); end
        bus.rd_addr = 11'd0;
        tick();
        total++; if (bus.rd_data !== exp_mem[0]) begin bad++; $display("[TB] FAIL rearm_retained got=%h want=%h", bus.rd_data, exp_mem[0]); end
    endtask

    task automatic test_reset_mid_capture();
        logic [9:0] s;
        feed(10'd100);
        exp_mem[0] = stored(10'd100);
        total++; if (bus.state !== 3'd2) begin bad++; $display("[TB] FAIL mid_trigger got=%0d want=2", bus.state); end
        for (int k = 1; k < 1000; k++) begin
            s = 10'(k) ^ 10'h155;
            exp_mem[k] = stored(s);
            feed(s);
        end
        total++; if (bus.sample_count !== 11'd1000) begin bad++; $display("[TB] FAIL mid_count got=%0d want=1000", bus.sample_count); end
        reset = 1'b1;
        tick();
        total++; if (bus.state !== 3'd0 || bus.sample_count !== 11'd0) begin
            bad++; $display("[TB] FAIL mid_reset state=%0d count=%0d want 0/0", bus.state, bus.sample_count);
        end
        total++; if (bus.busy !== 1'b0 || bus.capture_done !== 1'b0 || bus.rd_data !== 10'd0) begin
            bad++; $display("[TB] FAIL mid_reset_out busy=%b done=%b rd=%h want 0/0/0", bus.busy, bus.capture_done, bus.rd_data);
        end
        reset = 1'b0;
        for (int k = 0; k < 3; k++) feed(10'd900);
        total++; if (bus.state !== 3'd0 || bus.capture_done !== 1'b0) begin
            bad++; $display("[TB] FAIL mid_idle state=%0d done=%b want 0/0", bus.state, bus.capture_done);
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        feed(10'd1000);
        exp_mem[0] = stored(10'd1000);
        total++; if (bus.state !== 3'd2 || bus.sample_count !== 11'd1) begin
            bad++; $display("[TB] FAIL retrigger state=%0d count=%0d want 2/1", bus.state, bus.sample_count);
        end
        bus.rd_addr = 11'd0;
        tick();
        total++; if (bus.rd_data !== exp_mem[0]) begin bad++; $display("[TB] FAIL overwrite_0 got=%h want=%h", bus.rd_data, exp_mem[0]); end
        bus.rd_addr = 11'd1;
        tick();
        total++; if (bus.rd_data !== exp_mem[1]) begin bad++; $display("[TB] FAIL kept_1 got=%h want=%h", bus.rd_data, exp_mem[1]); end
        bus.rd_addr = 11'd1500;
        tick();
        total++; if (bus.rd_data !== exp_mem[1500]) begin bad++; $display("[TB] FAIL kept_1500 got=%h want=%h", bus.rd_data, exp_mem[1500]); end
    endtask

`ifdef AUDIO_CAPTURE_DC_REMOVE_EN
    task automatic test_dc_remove();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        feed(10'd600);
        feed(10'd400);
        bus.rd_addr = 11'd0;
        tick();
        total++; if (bus.rd_data !== 10'h058) begin bad++; $display("[TB] FAIL dc_word0 got=%h want=058", bus.rd_data); end
        bus.rd_addr = 11'd1;
        tick();
        total++; if (bus.rd_data !== 10'h390) begin bad++; $display("[TB] FAIL dc_word1 got=%h want=390", bus.rd_data); end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.start        = 1'b0;
        bus.sample_in    = 10'd512;
        bus.sample_valid = 1'b0;
        bus.rd_addr      = 11'd2000;
        @(negedge clk);
        test_reset();
        test_onset();
        test_full_capture();
        test_read_port();
        test_done_restart();
        test_reset_mid_capture();
`ifdef AUDIO_CAPTURE_DC_REMOVE_EN
        test_dc_remove();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
